// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM generators and the PWM meter.
// Holds FSM state encodings and default counter width.
package led_pkg;

   localparam int CNT_W_DEF = 16;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_MEASURE = 1'b1;

endpackage

// File: rtl/sync_edge.sv
// Input synchroniser chain with rising-edge detection.
// s_cur is the synchronised level, rise pulses on its 0->1 change.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic s_cur,
   output logic rise
);

   logic [STAGES-1:0] sync_q;
   logic              s_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         s_prev <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         s_prev <= sync_q[STAGES-1];
      end
   end

   assign s_cur = sync_q[STAGES-1];
   assign rise  = s_cur & ~s_prev;

endmodule

// File: rtl/pwm_meter.sv
// PWM period / high-time meter with stuck-input timeout.
// Reports once per input period; first edge after idle only arms.
module pwm_meter
   import led_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             timeout,
   output logic             level
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             s_cur;
   logic             rise;
   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hcnt;

   sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (pwm_in),
      .s_cur (s_cur),
      .rise  (rise)
   );

   assign level = s_cur;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         hcnt      <= '0;
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         valid <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (rise) begin
                  cnt   <= CNT_ONE;
                  hcnt  <= CNT_ONE;
                  state <= ST_MEASURE;
               end else begin
                  cnt  <= '0;
                  hcnt <= '0;
               end
            end
            ST_MEASURE: begin
               if (rise) begin
                  period    <= cnt;
                  high_time <= hcnt;
                  valid     <= 1'b1;
                  timeout   <= 1'b0;
                  cnt       <= CNT_ONE;
                  hcnt      <= CNT_ONE;
               end else if (cnt == CNT_MAX) begin
                  // Period too long to count: drop it and wait for a fresh edge
                  timeout <= 1'b1;
                  cnt     <= '0;
                  hcnt    <= '0;
                  state   <= ST_IDLE;
               end else begin
                  cnt  <= cnt + CNT_ONE;
                  hcnt <= hcnt + CNT_W'(s_cur);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_meter.sv
// Scoreboard bench for pwm_meter: 16-bit and 8-bit instances.
// Stimulus queues expected reports, monitors pop them on valid.
module tb_pwm_meter;

   typedef struct {
      int p;
      int h;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst16, rst8;
   logic        pwm16, pwm8;
   logic [15:0] per16, hi16;
   logic [7:0]  per8, hi8;
   logic        val16, val8;
   logic        to16, to8;
   logic        lvl16, lvl8;

   pwm_meter #(.CNT_W(16), .SYNC_STAGES(2)) u16 (
      .clk       (clk),
      .reset     (rst16),
      .pwm_in    (pwm16),
      .period    (per16),
      .high_time (hi16),
      .valid     (val16),
      .timeout   (to16),
      .level     (lvl16)
   );

   pwm_meter #(.CNT_W(8), .SYNC_STAGES(2)) u8 (
      .clk       (clk),
      .reset     (rst8),
      .pwm_in    (pwm8),
      .period    (per8),
      .high_time (hi8),
      .valid     (val8),
      .timeout   (to8),
      .level     (lvl8)
   );

   int   n_chk = 0;
   int   n_err = 0;
   exp_t q16[$];
   exp_t q8[$];
   int   armed[2];
   int   last_p[2];
   int   last_h[2];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pin(input int w, input logic v);
      if (w == 1) pwm8 = v;
      else pwm16 = v;
   endtask

   task automatic push(input int w, input int p, input int h);
      exp_t e;
      e.p = p;
      e.h = h;
      if (w == 1) q8.push_back(e);
      else q16.push_back(e);
   endtask

   // Each rising edge reports the previous period if one was being timed
   task automatic run(input int w, input int hi, input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         if (armed[w] != 0) push(w, last_p[w], last_h[w]);
         last_p[w] = hi + lo;
         last_h[w] = hi;
         armed[w]  = ((hi + lo) <= ((w == 1) ? 255 : 65535)) ? 1 : 0;
         set_pin(w, 1'b1);
         repeat (hi) tick();
         set_pin(w, 1'b0);
         repeat (lo) tick();
      end
   endtask

   int cyc16 = 0, last16 = 0, gap16 = 0;
   int cyc8 = 0, last8 = 0, gap8 = 0;

   always @(negedge clk) begin
      exp_t e;
      cyc16++;
      if (val16) begin
         if (q16.size() == 0) begin
            check("u16 unexpected valid", 1, 0);
         end else begin
            e = q16.pop_front();
            check("u16 period", int'(per16), e.p);
            check("u16 high_time", int'(hi16), e.h);
            check("u16 timeout at valid", int'(to16), 0);
            if (gap16 != 0) check("u16 valid spacing", cyc16 - last16, e.p);
         end
         gap16  = 1;
         last16 = cyc16;
      end
      if (to16 || !rst16) gap16 = 0;
   end

   always @(negedge clk) begin
      exp_t e;
      cyc8++;
      if (val8) begin
         if (q8.size() == 0) begin
            check("u8 unexpected valid", 1, 0);
         end else begin
            e = q8.pop_front();
            check("u8 period", int'(per8), e.p);
            check("u8 high_time", int'(hi8), e.h);
            check("u8 timeout at valid", int'(to8), 0);
            if (gap8 != 0) check("u8 valid spacing", cyc8 - last8, e.p);
         end
         gap8  = 1;
         last8 = cyc8;
      end
      if (to8 || !rst8) gap8 = 0;
   end

   initial begin
      int n;
      armed  = '{0, 0};
      last_p = '{0, 0};
      last_h = '{0, 0};
      rst16 = 1'b0;
      rst8  = 1'b0;
      pwm16 = 1'b0;
      pwm8  = 1'b0;
      repeat (3) tick();
      check("reset period16", int'(per16), 0);
      check("reset high16", int'(hi16), 0);
      check("reset valid16", int'(val16), 0);
      check("reset timeout16", int'(to16), 0);
      check("reset level16", int'(lvl16), 0);
      check("reset timeout8", int'(to8), 0);
      rst16 = 1'b1;
      rst8  = 1'b1;
      repeat (4) tick();

      // steady 54/20, then duty extremes
      run(0, 20, 34, 6);
      check("steady timeout16", int'(to16), 0);
      run(0, 1, 53, 2);
      run(0, 53, 1, 2);
      run(0, 20, 34, 1);

      // reset 30 cycles into a period
      push(0, 54, 20);
      pwm16 = 1'b1;
      repeat (20) tick();
      pwm16 = 1'b0;
      repeat (10) tick();
      check("pre-reset period16", int'(per16), 54);
      #2 rst16 = 1'b0;
      #1;
      check("async period16", int'(per16), 0);
      check("async high16", int'(hi16), 0);
      check("async valid16", int'(val16), 0);
      check("async timeout16", int'(to16), 0);
      check("async level16", int'(lvl16), 0);
      repeat (3) tick();
      rst16 = 1'b1;
      armed[0] = 0;
      repeat (24) tick();
      run(0, 20, 34, 3);
      check("post-reset period16", int'(per16), 54);
      check("u16 queue drained", q16.size(), 0);

      // stuck low after a valid measurement
      run(1, 5, 5, 3);
      n = 10;
      while (!to8 && n < 400) begin
         tick();
         n++;
      end
      check("stuck-low timeout delay", n, 258);
      armed[1] = 0;
      check("stuck-low level", int'(lvl8), 0);
      check("stuck-low period8", int'(per8), 10);
      check("stuck-low high8", int'(hi8), 5);

      // stuck high
      pwm8 = 1'b1;
      repeat (300) tick();
      check("stuck-high timeout", int'(to8), 1);
      check("stuck-high level", int'(lvl8), 1);
      check("stuck-high period8", int'(per8), 10);
      check("stuck-high high8", int'(hi8), 5);

      // recovery: first edge only arms
      pwm8 = 1'b0;
      repeat (5) tick();
      run(1, 4, 6, 1);
      check("recovery first edge timeout", int'(to8), 1);
      run(1, 4, 6, 2);
      check("recovery timeout cleared", int'(to8), 0);

      // boundary: 255 reported, 256 times out
      run(1, 100, 155, 2);
      run(1, 100, 156, 1);
      check("boundary 255 timeout", int'(to8), 0);
      run(1, 5, 5, 1);
      repeat (20) tick();
      check("boundary 256 timeout", int'(to8), 1);
      check("boundary period8", int'(per8), 255);
      check("boundary high8", int'(hi8), 100);
      check("u8 queue drained", q8.size(), 0);
      check("u16 queue final", q16.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
